// File: rtl/mini16_reset_seq_if.sv
// Bundle of the reset sequencer's control and status signals.
//   master : the sequencer. It takes soft_reset and ch_ready in and drives the
//            per-channel resets and the status outputs.
//   slave  : the consumer side. It drives soft_reset and ch_ready and observes
//            the resets and the status outputs.
//   soft_reset  synchronous restart request
//   ch_ready    per-channel "out of reset" acknowledge
//   ch_reset    per-channel active-high reset
//   seq_done    all channels released and acknowledged
//   timeout_err sticky ready-timeout flag
//   err_ch      index of the channel that timed out
//   tick_count  cycles elapsed in the run window
//   run_expired sticky flag, set once the run window is used up
interface mini16_reset_seq_if #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned WIDTH_CNT = 16
);
    logic                 soft_reset;
    logic [CHANNELS-1:0]  ch_ready;
    logic [CHANNELS-1:0]  ch_reset;
    logic                 seq_done;
    logic                 timeout_err;
    logic [3:0]           err_ch;
    logic [WIDTH_CNT-1:0] tick_count;
    logic                 run_expired;

    modport master (
        input  soft_reset, ch_ready,
        output ch_reset, seq_done, timeout_err, err_ch, tick_count, run_expired
    );

    modport slave (
        output soft_reset, ch_ready,
        input  ch_reset, seq_done, timeout_err, err_ch, tick_count, run_expired
    );
endinterface

// File: rtl/mini16_reset_seq.sv
// Releases CHANNELS reset domains one after another. It holds every domain in
// reset for HOLD_CYCLES cycles. It then releases channel 0 and waits for its
// ready. After GAP_CYCLES idle cycles it releases the next channel, and so on.
// Once every channel is acknowledged it enters a RUN window that counts up to
// RUN_TICKS. If a released channel is not acknowledged within READY_TIMEOUT
// cycles, the block raises a sticky error and forces every domain back into
// reset.
//   clk   single clock
//   reset asynchronous, active-high
//   bus   mini16_reset_seq_if.master (soft_reset, ch_ready in; resets and status out)
module mini16_reset_seq #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned HOLD_CYCLES   = 10,
    parameter int unsigned GAP_CYCLES    = 2,
    parameter int unsigned READY_TIMEOUT = 1000,
    parameter int unsigned RUN_TICKS     = 10000,
    parameter int unsigned WIDTH_CNT     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    mini16_reset_seq_if.master    bus
);
    localparam int unsigned IDX_W = 4;

    // Terminal values of the shared cycle counter for each state.
    localparam logic [WIDTH_CNT-1:0] HOLD_LAST = WIDTH_CNT'(HOLD_CYCLES - 1);
    localparam logic [WIDTH_CNT-1:0] GAP_LAST  = WIDTH_CNT'(GAP_CYCLES);
    localparam logic [WIDTH_CNT-1:0] TO_LAST   = WIDTH_CNT'(READY_TIMEOUT - 1);
    localparam logic [WIDTH_CNT-1:0] RUN_LAST  = WIDTH_CNT'(RUN_TICKS);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(CHANNELS - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT,
        S_GAP,
        S_RUN,
        S_ERROR
    } state_t;

    state_t               state_q, state_nxt;
    logic [WIDTH_CNT-1:0] cnt_q, cnt_nxt;
    logic [IDX_W-1:0]     idx_q, idx_nxt;

    logic [CHANNELS-1:0]  ch_reset_q, ch_reset_nxt;
    logic                 seq_done_q, seq_done_nxt;
    logic                 timeout_err_q, timeout_err_nxt;
    logic [3:0]           err_ch_q, err_ch_nxt;
    logic [WIDTH_CNT-1:0] tick_q, tick_nxt;
    logic                 run_expired_q, run_expired_nxt;

    logic ready_sel;
    logic hold_done;
    logic gap_done;
    logic to_hit;

    // Ready of the channel currently being waited on. Ready bits of the other
    // channels never reach the control logic.
    always_comb begin
        ready_sel = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                ready_sel = bus.ch_ready[i];
            end
        end
    end

    assign hold_done = (cnt_q == HOLD_LAST);
    assign gap_done  = (cnt_q == GAP_LAST);
    assign to_hit    = (cnt_q == TO_LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            idx_q   <= idx_nxt;
        end
    end

    // Next-state logic. A single counter serves as the hold, gap and timeout
    // timer, because only one of them is ever active at a time.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        idx_nxt   = idx_q;
        if (bus.soft_reset) begin
            state_nxt = S_HOLD;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    if (hold_done) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = '0;
                        idx_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_q + WIDTH_CNT'(1);
                    end
                end
                S_WAIT: begin
                    if (ready_sel) begin
                        cnt_nxt   = '0;
                        state_nxt = (idx_q == LAST_IDX) ? S_RUN : S_GAP;
                    end else if (to_hit) begin
                        cnt_nxt   = '0;
                        state_nxt = S_ERROR;
                    end else begin
                        cnt_nxt = cnt_q + WIDTH_CNT'(1);
                    end
                end
                S_GAP: begin
                    if (gap_done) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = '0;
                        idx_nxt   = idx_q + IDX_W'(1);
                    end else begin
                        cnt_nxt = cnt_q + WIDTH_CNT'(1);
                    end
                end
                S_RUN:   state_nxt = S_RUN;
                S_ERROR: state_nxt = S_ERROR;
                default: state_nxt = S_HOLD;
            endcase
        end
    end

    // Output logic: the values the output registers take on the next edge.
    always_comb begin
        ch_reset_nxt    = ch_reset_q;
        seq_done_nxt    = seq_done_q;
        timeout_err_nxt = timeout_err_q;
        err_ch_nxt      = err_ch_q;
        tick_nxt        = tick_q;
        run_expired_nxt = run_expired_q;
        if (bus.soft_reset) begin
            ch_reset_nxt    = '1;
            seq_done_nxt    = 1'b0;
            timeout_err_nxt = 1'b0;
            err_ch_nxt      = '0;
            tick_nxt        = '0;
            run_expired_nxt = 1'b0;
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    ch_reset_nxt = '1;
                    if (hold_done) begin
                        ch_reset_nxt[0] = 1'b0;
                    end
                end
                S_WAIT: begin
                    if (!ready_sel && to_hit) begin
                        ch_reset_nxt    = '1;
                        timeout_err_nxt = 1'b1;
                        err_ch_nxt      = idx_q;
                    end
                end
                S_GAP: begin
                    // The gap ends with the release of the channel after idx.
                    for (int i = 1; i < CHANNELS; i++) begin
                        if (gap_done && (idx_q == IDX_W'(i - 1))) begin
                            ch_reset_nxt[i] = 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    seq_done_nxt = 1'b1;
                    if (tick_q != RUN_LAST) begin
                        tick_nxt = tick_q + WIDTH_CNT'(1);
                    end else begin
                        run_expired_nxt = 1'b1;
                    end
                end
                S_ERROR: ch_reset_nxt = '1;
                default: ch_reset_nxt = '1;
            endcase
        end
    end

    // Output registers. Reset takes every domain back into reset asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_reset_q    <= '1;
            seq_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            err_ch_q      <= '0;
            tick_q        <= '0;
            run_expired_q <= 1'b0;
        end else begin
            ch_reset_q    <= ch_reset_nxt;
            seq_done_q    <= seq_done_nxt;
            timeout_err_q <= timeout_err_nxt;
            err_ch_q      <= err_ch_nxt;
            tick_q        <= tick_nxt;
            run_expired_q <= run_expired_nxt;
        end
    end

    assign bus.ch_reset    = ch_reset_q;
    assign bus.seq_done    = seq_done_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.err_ch      = err_ch_q;
    assign bus.tick_count  = tick_q;
    assign bus.run_expired = run_expired_q;
endmodule

// File: tb/tb_mini16_reset_seq.sv
// Self-checking bench for mini16_reset_seq. It runs two instances:
//   A : 4 channels, gap 2, timeout 1000, run window 100
//   B : 1 channel,  gap 0, timeout 20,   run window 15
// Each scenario draws a ready latency for every channel. From those latencies
// the expected release, acknowledge, timeout and run edges are worked out with
// plain arithmetic, and every edge is checked against them. Ready bits that
// must be ignored (unreleased channels, channels already acknowledged, the RUN
// window) are driven randomly.
module tb_mini16_reset_seq;
    localparam int HOLD = 10;

    logic       clk = 1'b0;
    logic       drv_reset;
    logic       drv_soft;
    logic [3:0] drv_ready;
    int         sel;

    logic reset_a, reset_b;

    int cfg_ch  [2] = '{4, 1};
    int cfg_gap [2] = '{2, 0};
    int cfg_to  [2] = '{1000, 20};
    int cfg_rt  [2] = '{100, 15};

    int lat [4];
    int rel [4];
    int ack [4];
    int err_edge, err_idx, run_start;
    int edge_n;
    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    mini16_reset_seq_if #(.CHANNELS(4), .WIDTH_CNT(16)) if_a ();
    mini16_reset_seq_if #(.CHANNELS(1), .WIDTH_CNT(16)) if_b ();

    // Only the selected instance sees the stimulus; the other one stays in reset.
    assign reset_a         = (sel == 0) ? drv_reset : 1'b1;
    assign reset_b         = (sel == 1) ? drv_reset : 1'b1;
    assign if_a.soft_reset = (sel == 0) && drv_soft;
    assign if_b.soft_reset = (sel == 1) && drv_soft;
    assign if_a.ch_ready   = drv_ready;
    assign if_b.ch_ready   = drv_ready[0:0];

    mini16_reset_seq #(
        .CHANNELS(4), .HOLD_CYCLES(HOLD), .GAP_CYCLES(2),
        .READY_TIMEOUT(1000), .RUN_TICKS(100), .WIDTH_CNT(16)
    ) u_dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (if_a)
    );

    mini16_reset_seq #(
        .CHANNELS(1), .HOLD_CYCLES(HOLD), .GAP_CYCLES(0),
        .READY_TIMEOUT(20), .RUN_TICKS(15), .WIDTH_CNT(16)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (if_b)
    );

    logic [3:0]  o_rst;
    logic        o_done, o_terr, o_rexp;
    logic [3:0]  o_errch;
    logic [15:0] o_tick;

    always_comb begin
        if (sel == 0) begin
            o_rst   = if_a.ch_reset;
            o_done  = if_a.seq_done;
            o_terr  = if_a.timeout_err;
            o_errch = if_a.err_ch;
            o_tick  = if_a.tick_count;
            o_rexp  = if_a.run_expired;
        end else begin
            o_rst   = {3'b111, if_b.ch_reset};
            o_done  = if_b.seq_done;
            o_terr  = if_b.timeout_err;
            o_errch = if_b.err_ch;
            o_tick  = if_b.tick_count;
            o_rexp  = if_b.run_expired;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s dut=%0d edge=%0d got=%0h exp=%0h", tag, sel, edge_n, obs, exp);
        end
    endtask

    // Expected timeline, in edges counted from the reset release or from the
    // last edge that saw soft_reset high.
    task automatic build_model();
        int  c;
        bool_stop: begin end
        c = cfg_ch[sel];
        for (int i = 0; i < 4; i++) begin
            rel[i] = -1;
            ack[i] = -1;
        end
        rel[0]    = HOLD;
        err_edge  = -1;
        err_idx   = 0;
        run_start = -1;
        for (int i = 0; i < 4; i++) begin
            if (i < c && rel[i] >= 0) begin
                if (lat[i] > cfg_to[sel]) begin
                    err_edge = rel[i] + cfg_to[sel];
                    err_idx  = i;
                end else begin
                    ack[i] = rel[i] + lat[i];
                    if (i == c - 1) run_start = ack[i];
                    else            rel[i+1]  = ack[i] + cfg_gap[sel] + 1;
                end
            end
        end
    endtask

    task automatic check_edge(input int n);
        logic [3:0] e_rst;
        logic       e_err;
        int         t;
        int         rt;
        rt    = cfg_rt[sel];
        e_err = (err_edge >= 0) && (n >= err_edge);
        e_rst = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            if (i < cfg_ch[sel]) e_rst[i] = e_err || (rel[i] < 0) || (n < rel[i]);
        end
        t = 0;
        if (run_start >= 0 && n >= run_start) begin
            t = n - run_start;
            if (t > rt) t = rt;
        end
        chk("ch_reset",    32'(o_rst),   32'(e_rst));
        chk("seq_done",    32'(o_done),  32'(run_start >= 0 && n >= run_start + 1));
        chk("timeout_err", 32'(o_terr),  32'(e_err));
        chk("err_ch",      32'(o_errch), e_err ? 32'(err_idx) : 32'd0);
        chk("tick_count",  32'(o_tick),  32'(t));
        chk("run_expired", 32'(o_rexp),  32'(run_start >= 0 && n >= run_start + rt + 1));
    endtask

    // Ready values for edge m. A released channel reads 0 until its ack edge
    // and 1 on it; every bit the sequencer must ignore is random.
    task automatic set_ready(input int m);
        for (int i = 0; i < 4; i++) begin
            logic r;
            r = 1'($urandom_range(0, 1));
            if (i < cfg_ch[sel] && rel[i] >= 0 && m > rel[i]) begin
                if (ack[i] < 0 || m < ack[i]) r = 1'b0;
                else if (m == ack[i])         r = 1'b1;
            end
            drv_ready[i] = r;
        end
    endtask

    // Starts at a falling edge, restarts the selected instance (asynchronous
    // reset or a soft_reset pulse), then runs len edges, checking each one.
    task automatic run_scn(input bit use_soft, input int len);
        build_model();
        edge_n = 0;
        if (!use_soft) begin
            drv_soft  = 1'b0;
            drv_reset = 1'b1;
            #1;
            check_edge(0);
            repeat ($urandom_range(1, 2)) begin
                @(negedge clk);
                check_edge(0);
            end
            drv_reset = 1'b0;
        end else begin
            drv_soft  = 1'b1;
            drv_ready = 4'($urandom());
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                check_edge(0);
                drv_ready = 4'($urandom());
            end
            drv_soft = 1'b0;
        end
        set_ready(1);
        for (int n = 1; n <= len; n++) begin
            @(negedge clk);
            edge_n = n;
            check_edge(n);
            set_ready(n + 1);
        end
    endtask

    task automatic set_lat_all(input int v);
        for (int i = 0; i < 4; i++) lat[i] = v;
    endtask

    task automatic rand_lat();
        for (int i = 0; i < 4; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0)      lat[i] = cfg_to[sel] + 1;
            else if (r == 1) lat[i] = cfg_to[sel];
            else             lat[i] = int'($urandom_range(1, 5));
        end
    endtask

    initial begin
        sel       = 0;
        drv_reset = 1'b1;
        drv_soft  = 1'b0;
        drv_ready = '0;
        edge_n    = 0;
        repeat (2) @(negedge clk);

        // Instance A: nominal sequence and run-window saturation.
        set_lat_all(1);
        run_scn(1'b0, 140);
        // Soft restart out of RUN while ready toggles.
        set_lat_all(1);
        run_scn(1'b1, 40);
        // Stop inside the gap after channel 1; the next start resets asynchronously.
        set_lat_all(1);
        run_scn(1'b0, 16);
        // Channel 2 never acknowledges.
        set_lat_all(1);
        lat[2] = 5000;
        run_scn(1'b0, 1030);
        // Soft restart out of ERROR.
        set_lat_all(2);
        run_scn(1'b1, 60);
        for (int s = 0; s < 10; s++) begin
            rand_lat();
            run_scn(1'($urandom_range(0, 1)), int'($urandom_range(20, 160)));
        end

        // Instance B: single channel, zero gap.
        drv_reset = 1'b1;
        sel       = 1;
        set_lat_all(1);
        run_scn(1'b0, 40);
        set_lat_all(1);
        lat[0] = 30;
        run_scn(1'b0, 40);
        set_lat_all(20);
        run_scn(1'b1, 45);
        for (int s = 0; s < 6; s++) begin
            rand_lat();
            run_scn(1'($urandom_range(0, 1)), int'($urandom_range(20, 60)));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/mini16_reset_seq.md
MINI16_RESET_SEQ -- requirements
Module: mini16_reset_seq

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of sequenced reset domains (1..16).
REQ-002 SHALL have parameter HOLD_CYCLES, default 10, number of cycles all channels are held in reset after reset or soft_reset (>=1).
REQ-003 SHALL have parameter GAP_CYCLES, default 2, number of idle cycles between ready of channel i and release of channel i+1 (>=0).
REQ-004 SHALL have parameter READY_TIMEOUT, default 1000, maximum number of cycles spent waiting for ch_ready of the released channel (>=1).
REQ-005 SHALL have parameter RUN_TICKS, default 10000, run-window length in cycles (>=1).
REQ-006 SHALL have parameter WIDTH_CNT, default 16, width of all internal counters and tick_count; every count parameter SHALL fit in WIDTH_CNT bits.
REQ-007 SHALL have port clk, input, 1, single clock; all logic sits in this domain.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port soft_reset, input, 1, synchronous restart request, sampled on the rising edge of clk.
REQ-010 SHALL have port ch_ready, input, CHANNELS, per-channel "out of reset" acknowledge.
REQ-011 SHALL have port ch_reset, output, CHANNELS, registered per-channel active-high reset.
REQ-012 SHALL have port seq_done, output, 1, all channels released and acknowledged.
REQ-013 SHALL have port timeout_err, output, 1, sticky ready-timeout flag.
REQ-014 SHALL have port err_ch, output, 4, index of the channel that timed out.
REQ-015 SHALL have port tick_count, output, WIDTH_CNT, cycles elapsed in RUN.
REQ-016 SHALL have port run_expired, output, 1, sticky flag set when tick_count reaches RUN_TICKS.

Function
REQ-017 SHALL implement the states HOLD, WAIT_READY, GAP, RUN and ERROR, with channel index idx.
REQ-018 HOLD SHALL drive all ch_reset=1; after HOLD_CYCLES edges it SHALL set idx=0, clear ch_reset[0] and enter WAIT_READY.
REQ-019 If reset is released before edge 1, ch_reset[0] SHALL fall on edge HOLD_CYCLES.
REQ-020 WAIT_READY SHALL sample ch_ready[idx] each edge; high when idx<CHANNELS-1 SHALL enter GAP, and high when idx==CHANNELS-1 SHALL enter RUN.
REQ-021 If ch_ready[idx] is sampled high at edge E, ch_reset[idx+1] SHALL fall at edge E+GAP_CYCLES+1 and idx SHALL increment; GAP_CYCLES=0 SHALL release on E+1.
REQ-022 Once released, a channel SHALL stay out of reset until soft_reset, reset or ERROR.
REQ-023 WAIT_READY SHALL count cycles without ready; READY_TIMEOUT consecutive un-acked edges after release SHALL enter ERROR.
REQ-024 On entering ERROR, timeout_err=1, err_ch=idx and all ch_reset=1 SHALL be set; ERROR SHALL be left only by soft_reset or reset.
REQ-025 After the last ready sampled at edge E, seq_done SHALL rise at edge E+1 and stay high in RUN.
REQ-026 In RUN, tick_count SHALL start at 0 and increment each edge, saturating at RUN_TICKS with run_expired=1 (sticky).
REQ-027 ch_ready changes in RUN SHALL be ignored.
REQ-028 ch_ready bits of unreleased channels SHALL be ignored.
REQ-029 soft_reset high at any edge, in any state, SHALL enter HOLD with all ch_reset=1, and SHALL clear seq_done, timeout_err, err_ch, tick_count, run_expired and counters; HOLD_CYCLES counting SHALL begin after soft_reset falls.
REQ-030 soft_reset SHALL win over a simultaneous ready or timeout on the same edge.
REQ-031 Holding soft_reset high SHALL keep the block in HOLD.

Reset
REQ-032 While reset=1: ch_reset all 1, seq_done=0, timeout_err=0, err_ch=0, tick_count=0, run_expired=0, state HOLD, idx=0 and counters 0, independent of clk.
REQ-033 Reset asserted mid-sequence or in RUN SHALL immediately (asynchronously) reassert all ch_reset.

Verification
REQ-034 Defaults, ch_ready all 1, reset released before edge 1 -> ch_reset[0..3] fall at edges 10, 14, 18, 22; seq_done rises at edge 24.
REQ-035 Defaults, ch_ready[2]=0 -> ch_reset[2] falls at edge 18; timeout_err=1 and err_ch=2 at edge 1018; all ch_reset=1; seq_done stays 0.
REQ-036 RUN_TICKS=100, ready all 1 -> tick_count reaches 100 and holds, run_expired=1 one edge later and remains set.
REQ-037 soft_reset pulsed one cycle during RUN, together with a ready toggle -> all ch_reset=1 next edge; flags cleared; the sequence repeats with the REQ-034 timing relative to soft_reset fall.
REQ-038 reset asserted asynchronously mid-GAP -> all ch_reset=1 without a clk edge; full restart after release.
REQ-039 GAP_CYCLES=0, CHANNELS=1 -> ch_reset[0] falls at edge 10; ready sampled at edge 11; seq_done rises at edge 12.
